// File: rtl/tf_round_engine.sv
// Iterative Threefish-1024 round engine: NR rounds, UNROLL rounds per clock, subkeys fetched by request/valid.
// Optional Skein UBI feed-forward of the plaintext onto the output is enabled with `define TF_UBI_FF_EN.
module tf_round_engine #(
  parameter int NR     = 80,
  parameter int UNROLL = 1,
  parameter int SKW    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1023:0]   in_block,
  output logic            sk_req,
  output logic [SKW-1:0]  sk_idx,
  input  logic            sk_valid,
  input  logic [1023:0]   sk_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1023:0]   out_block
);

  localparam int DW = $clog2(NR + 1);
  localparam logic [DW-1:0]  D_STEP = DW'(UNROLL);
  localparam logic [DW-1:0]  D_LAST = DW'(NR);
  localparam logic [SKW-1:0] SK_ONE = SKW'(1);

  localparam int ROT [0:63] = '{
    24, 13,  8, 47,  8, 17, 22, 37,
    38, 19, 10, 55, 49, 18, 23, 52,
    33,  4, 51, 13, 34, 41, 59, 17,
     5, 20, 48, 41, 47, 28, 16, 25,
    41,  9, 37, 31, 12, 47, 44, 30,
    16, 34, 56, 51,  4, 53, 42, 41,
    31, 44, 47, 46, 19, 42, 44, 25,
     9, 48, 35, 52, 23, 31, 37, 20
  };
  localparam int PI [0:15] = '{0, 9, 2, 13, 6, 11, 4, 15, 10, 7, 12, 3, 14, 5, 8, 1};

  typedef enum logic [1:0] {S_IDLE, S_INJECT, S_ROUND, S_DONE} fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [DW-1:0]    d_q;
  logic [DW-1:0]    d_nxt;
  logic [SKW-1:0]   s_q;
  logic [1023:0]    blk_p0;
  logic [1023:0]    rnd_out;
`ifdef TF_UBI_FF_EN
  logic [1023:0]    pt_p0;
`endif

  function automatic logic [63:0] rotl64(input logic [63:0] x, input logic [5:0] n);
    return (x << n) | (x >> (7'd64 - {1'b0, n}));
  endfunction

  function automatic logic [1023:0] add_words(input logic [1023:0] a, input logic [1023:0] b);
    logic [1023:0] y;
    for (int j = 0; j < 16; j++) y[64*j +: 64] = a[64*j +: 64] + b[64*j +: 64];
    return y;
  endfunction

  // One MIX layer over the eight word pairs followed by the word permutation.
  function automatic logic [1023:0] tf_round(input logic [1023:0] x, input logic [2:0] r);
    logic [1023:0] m;
    logic [1023:0] y;
    logic [63:0]   a, b, s;
    for (int j = 0; j < 8; j++) begin
      a = x[128*j +: 64];
      b = x[128*j+64 +: 64];
      s = a + b;
      m[128*j +: 64]    = s;
      m[128*j+64 +: 64] = rotl64(b, 6'(ROT[{r, 3'(j)}])) ^ s;
    end
    for (int i = 0; i < 16; i++) y[64*i +: 64] = m[64*PI[i] +: 64];
    return y;
  endfunction

  assign d_nxt = d_q + D_STEP;

  always_comb begin
    rnd_out = blk_p0;
    for (int u = 0; u < UNROLL; u++) rnd_out = tf_round(rnd_out, d_q[2:0] + 3'(u));
  end

  always_ff @(posedge clk) begin
    if (!reset) fsm_q <= S_IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:   if (in_valid) fsm_d = S_INJECT;
      S_INJECT: if (sk_valid) fsm_d = (d_q == D_LAST) ? S_DONE : S_ROUND;
      S_ROUND:  if (d_nxt[1:0] == 2'b00) fsm_d = S_INJECT;
      S_DONE:   if (out_ready) fsm_d = S_IDLE;
      default:  fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (fsm_q == S_IDLE);
    sk_req    = (fsm_q == S_INJECT);
    out_valid = (fsm_q == S_DONE);
    sk_idx    = '0;
    if (fsm_q == S_INJECT) sk_idx = s_q;
  end

  // Block state register: load, subkey add, or UNROLL rounds per clock.
  always_ff @(posedge clk) begin
    if (!reset) begin
      d_q    <= '0;
      s_q    <= '0;
      blk_p0 <= '0;
`ifdef TF_UBI_FF_EN
      pt_p0  <= '0;
`endif
    end else begin
      case (fsm_q)
        S_IDLE: if (in_valid) begin
          blk_p0 <= in_block;
          d_q    <= '0;
          s_q    <= '0;
`ifdef TF_UBI_FF_EN
          pt_p0  <= in_block;
`endif
        end
        S_INJECT: if (sk_valid) begin
          blk_p0 <= add_words(blk_p0, sk_data);
          s_q    <= s_q + SK_ONE;
        end
        S_ROUND: begin
          blk_p0 <= rnd_out;
          d_q    <= d_nxt;
        end
        default: ;
      endcase
    end
  end

`ifdef TF_UBI_FF_EN
  assign out_block = blk_p0 ^ pt_p0;
`else
  assign out_block = blk_p0;
`endif

endmodule

// File: tb/tb_tf_round_engine.sv
// Scoreboard bench for tf_round_engine against a word-array Threefish-1024 reference model.
`timescale 1ns/1ps
module tb_tf_round_engine;
  parameter int UNROLL = 1;
  localparam int NR       = 80;
  localparam int SKW      = 5;
  localparam int NSK      = NR/4 + 1;
  localparam int BASE_LAT = NSK + NR/UNROLL;
  localparam int RST_AT   = (UNROLL == 1) ? 47 : BASE_LAT/2;
  localparam logic [63:0] C240 = 64'h1BD11BDAA9FC1A22;
  localparam int ROT [0:63] = '{
    24, 13,  8, 47,  8, 17, 22, 37,
    38, 19, 10, 55, 49, 18, 23, 52,
    33,  4, 51, 13, 34, 41, 59, 17,
     5, 20, 48, 41, 47, 28, 16, 25,
    41,  9, 37, 31, 12, 47, 44, 30,
    16, 34, 56, 51,  4, 53, 42, 41,
    31, 44, 47, 46, 19, 42, 44, 25,
     9, 48, 35, 52, 23, 31, 37, 20
  };
  localparam int PI [0:15] = '{0, 9, 2, 13, 6, 11, 4, 15, 10, 7, 12, 3, 14, 5, 8, 1};

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid, in_ready;
  logic [1023:0]  in_block;
  logic           sk_req, sk_valid;
  logic [SKW-1:0] sk_idx;
  logic [1023:0]  sk_data;
  logic           out_valid, out_ready;
  logic [1023:0]  out_block;

  always #5 clk = ~clk;

  tf_round_engine #(.NR(NR), .UNROLL(UNROLL), .SKW(SKW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .sk_req(sk_req), .sk_idx(sk_idx), .sk_valid(sk_valid), .sk_data(sk_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block)
  );

  typedef struct { logic [1023:0] exp; int hs; int stall0; } exp_t;
  exp_t          sb[$];
  logic [1023:0] cur_sk [0:NSK-1];
  logic [1023:0] pend_exp;
  int  n_vec = 0, n_err = 0, cyc = 0, stall_cnt = 0, sk_mode = 0;
  int  sk_exp = 0, stall_left = 0;
  bit  stall_done = 1'b0, rnd_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1023:0] rand_blk();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  // Threefish-1024 key schedule: 17 key words with parity, 3 tweak words.
  function automatic logic [1023:0] subkey(input logic [1023:0] key, input logic [127:0] tw, input int s);
    logic [63:0]   k [17];
    logic [63:0]   t [3];
    logic [1023:0] r;
    k[16] = C240;
    for (int i = 0; i < 16; i++) begin
      k[i]  = key[64*i +: 64];
      k[16] = k[16] ^ k[i];
    end
    t[0] = tw[63:0];
    t[1] = tw[127:64];
    t[2] = t[0] ^ t[1];
    for (int i = 0; i < 16; i++) r[64*i +: 64] = k[(s + i) % 17];
    r[64*13 +: 64] = r[64*13 +: 64] + t[s % 3];
    r[64*14 +: 64] = r[64*14 +: 64] + t[(s + 1) % 3];
    r[64*15 +: 64] = r[64*15 +: 64] + 64'(s);
    return r;
  endfunction

  function automatic logic [1023:0] tf_model(input logic [1023:0] pt, input logic [1023:0] key, input logic [127:0] tw);
    logic [63:0]   x [16];
    logic [63:0]   m [16];
    logic [1023:0] sk, r;
    for (int i = 0; i < 16; i++) x[i] = pt[64*i +: 64];
    for (int d = 0; d < NR; d++) begin
      if (d % 4 == 0) begin
        sk = subkey(key, tw, d/4);
        for (int i = 0; i < 16; i++) x[i] = x[i] + sk[64*i +: 64];
      end
      for (int j = 0; j < 8; j++) begin
        m[2*j]   = x[2*j] + x[2*j+1];
        m[2*j+1] = rotl(x[2*j+1], ROT[8*(d % 8) + j]) ^ m[2*j];
      end
      for (int i = 0; i < 16; i++) x[i] = m[PI[i]];
    end
    sk = subkey(key, tw, NR/4);
    for (int i = 0; i < 16; i++) r[64*i +: 64] = x[i] + sk[64*i +: 64];
    return r;
  endfunction

  function automatic logic [1023:0] expect_of(input logic [1023:0] pt, input logic [1023:0] key, input logic [127:0] tw);
`ifdef TF_UBI_FF_EN
    return tf_model(pt, key, tw) ^ pt;
`else
    return tf_model(pt, key, tw);
`endif
  endfunction

  function automatic int diff_word(input logic [1023:0] a, input logic [1023:0] b);
    for (int i = 0; i < 16; i++) if (a[64*i +: 64] !== b[64*i +: 64]) return i;
    return 0;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, got, want);
    end
  endtask

  task automatic chk_blk(input string nm, input logic [1023:0] got, input logic [1023:0] want);
    int w;
    n_vec++;
    if (got !== want) begin
      n_err++;
      w = diff_word(got, want);
      $display("FAIL %s: word %0d got %h, required %h", nm, w, got[64*w +: 64], want[64*w +: 64]);
    end
  endtask

  task automatic offer(input logic [1023:0] pt, input logic [1023:0] key, input logic [127:0] tw);
    for (int s = 0; s < NSK; s++) cur_sk[s] = subkey(key, tw, s);
    pend_exp = expect_of(pt, key, tw);
    in_block = pt;
    in_valid = 1'b1;
  endtask

  task automatic accept(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (in_ready) begin
        sb.push_back('{exp: pend_exp, hs: cyc + 1, stall0: stall_cnt});
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_block = rand_blk();
        return;
      end
      @(posedge clk); #1;
    end
    n_vec++; n_err++;
    $display("FAIL accept: in_ready stayed 0 for %0d cycles, required 1", budget);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) begin
        out_ready = 1'b1;
        return;
      end
      if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    n_vec++; n_err++;
    $display("FAIL done_timeout: %0d results pending after %0d cycles, required 0", sb.size(), budget);
    sb.delete();
    out_ready = 1'b1;
  endtask

  // Subkey server: checks the index sequence and applies the selected stall pattern.
  always begin
    bit go;
    @(posedge clk); #1;
    if (!reset) begin
      sk_exp = 0; sk_valid = 1'b0; stall_left = 0; stall_done = 1'b0;
    end else if (sk_req) begin
      chk("sk_idx", int'(sk_idx), sk_exp);
      go = 1'b1;
      if (sk_mode == 1 && int'(sk_idx) == 3 && !stall_done) begin
        stall_left = 5;
        stall_done = 1'b1;
      end
      if (stall_left > 0) begin
        go = 1'b0;
        stall_left--;
      end
      if (sk_mode == 2) go = ($urandom_range(0, 3) != 0);
      sk_valid = go;
      if (go) begin
        sk_data = (int'(sk_idx) < NSK) ? cur_sk[int'(sk_idx)] : '0;
        sk_exp++;
      end else begin
        sk_data = rand_blk();
        stall_cnt++;
      end
    end else begin
      if (stall_left > 0) begin
        n_vec++; n_err++;
        $display("FAIL sk_req_hold: sk_req=0 during stall, required 1");
        stall_left = 0;
      end
      sk_valid = ($urandom_range(0, 1) != 0);
      sk_data  = rand_blk();
      if (in_ready) begin
        sk_exp = 0;
        stall_done = 1'b0;
      end
    end
  end

  // Output monitor: latency on the rising edge of out_valid, hold while stalled, data on handshake.
  logic          ov_prev = 1'b0;
  logic [1023:0] held;
  exp_t          e;
  always @(negedge clk) begin
    if (!reset) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        held = out_block;
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_out: out_valid=1 with no block outstanding, required 0");
        end else begin
          chk("latency", cyc - sb[0].hs, BASE_LAT + stall_cnt - sb[0].stall0);
        end
      end else if (out_valid) begin
        chk_blk("out_hold", out_block, held);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk_blk("out_block", out_block, e.exp);
      end
      ov_prev = out_valid;
    end
  end

  initial begin
    int k;
    reset = 1'b0; in_valid = 1'b0; in_block = '0; out_ready = 1'b1;
    sk_valid = 1'b0; sk_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_sk_req", int'(sk_req), 0);
    chk("rst_sk_idx", int'(sk_idx), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk_blk("rst_out_block", out_block, '0);
    reset = 1'b1;

    // zero key/tweak/plaintext known answer
    offer('0, '0, '0); accept(10); wait_done(400);

    // five-cycle subkey stall at index 3
    sk_mode = 1;
    offer('0, '0, '0); accept(10); wait_done(400);
    sk_mode = 0;

    // backpressure in DONE with a second block offered throughout
    out_ready = 1'b0;
    offer(rand_blk(), rand_blk(), '0); accept(10);
    for (k = 0; k < 400 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("bp_reach_done", int'(out_valid), 1);
    offer(rand_blk(), rand_blk(), {$urandom(), $urandom(), $urandom(), $urandom()});
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after", int'(in_ready), 1);
    chk("bp_out_valid_after", int'(out_valid), 0);
    accept(1); wait_done(400);

    // random keys, tweaks, plaintexts, subkey stalls and output backpressure
    sk_mode = 2; rnd_ready = 1'b1;
    repeat (4) begin
      offer(rand_blk(), rand_blk(), {$urandom(), $urandom(), $urandom(), $urandom()});
      accept(10); wait_done(1500);
    end
    sk_mode = 0; rnd_ready = 1'b0; out_ready = 1'b1;

    // reset mid-operation, then a clean known-answer block
    offer('0, '0, '0); accept(10);
    repeat (RST_AT) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_sk_req", int'(sk_req), 0);
    chk("mid_rst_sk_idx", int'(sk_idx), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk_blk("mid_rst_out_block", out_block, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    offer('0, '0, '0); accept(10); wait_done(400);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tf_round_engine.md
Name: tf_round_engine

Overview:
- Iterative Threefish-1024 encryption core. Runs NR rounds over a 1024-bit block, UNROLL rounds per clock.
- Pulls subkeys from the key scheduler through a request/valid handshake and injects one every 4 rounds.
- Sits between the UBI message loader and the hash-compare stage. Replaces the single combinational round with a registered, parametrised, flow-controlled engine.

Parameters:
- NR, 80: total rounds. Must be a multiple of 4, minimum 4.
- UNROLL, 1: rounds evaluated per clock. Legal values are 1, 2 and 4.
- SKW, 5: width of the subkey index. Must satisfy 2^SKW > NR/4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  plaintext block offered.
- in_ready  out  1  engine can accept a block.
- in_block  in  1024  plaintext; word j = bits [64j+63:64j].
- sk_req  out  1  subkey request.
- sk_idx  out  SKW  index s of the requested subkey.
- sk_valid  in  1  subkey present on sk_data.
- sk_data  in  1024  subkey words, same word order as in_block.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_block  out  1024  ciphertext, or UBI output when TF_UBI_FF_EN is set.

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM goes to IDLE; round counter d=0; subkey index s=0.
  - in_ready=1, sk_req=0, sk_idx=0, out_valid=0, out_block=0, state register=0.
  - Reset wins over any concurrent handshake, including mid-operation; a partial result is discarded.
- States: IDLE, INJECT, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready: state <= in_block; d=0; s=0; next state INJECT.
  - in_ready is 0 in every other state; in_valid outside IDLE is ignored.
- INJECT:
  - sk_req=1, sk_idx=s.
  - On sk_valid: each word j of state <= state[j] + sk_data[j] (mod 2^64); s<=s+1.
  - After the inject: if d==NR, go to DONE; otherwise go to ROUND.
  - While sk_valid=0, hold. sk_data is sampled only when sk_req&&sk_valid; sk_valid while sk_req=0 is ignored.
- ROUND, one clock applies UNROLL consecutive rounds, each defined as:
  - MIX for pair j=0..7: y0 = x[2j] + x[2j+1] (mod 2^64); y1 = rotl64(x[2j+1], R[d mod 8][j]) ^ y0.
  - R is the team's Threefish-1024 rotation table, the same table as tf_rotate.
  - Permute: out word i = mixed word pi(i), with pi = 0,9,2,13,6,11,4,15,10,7,12,3,14,5,8,1.
  - d <= d+UNROLL. When d reaches a multiple of 4, go to INJECT; otherwise stay in ROUND.
- DONE:
  - out_valid=1; out_block is the final state.
  - Both are held stable while out_ready=0.
  - On out_valid&&out_ready: out_valid<=0 and go to IDLE. in_ready rises the following cycle; there is no same-cycle overlap.
- Sequence per block:
  - NR/4+1 injections, with s = 0..NR/4.
  - NR/UNROLL ROUND cycles.
- Latency with sk_valid tied high: out_valid rises (NR/4+1)+NR/UNROLL edges after the input-handshake edge.
  - NR=80, UNROLL=1: 101 edges. NR=80, UNROLL=4: 41 edges.
  - Each cycle of sk_valid low adds exactly one cycle.

Optional Feature:
- Macro: TF_UBI_FF_EN.
- Defined:
  - The engine keeps a 1024-bit copy of in_block captured at the input handshake.
  - out_block = final_state ^ saved_plaintext (Skein UBI feed-forward).
  - The saved copy resets to 0.
- Undefined:
  - No copy register is built.
  - out_block = final_state (raw Threefish ciphertext).

Test Plan:
- Reset state: hold reset=0 for 3 cycles -> in_ready=1, sk_req=0, sk_idx=0, out_valid=0, out_block=0.
- Known answer:
  - Stimulus: NR=80, UNROLL=1, sk_valid=1, subkeys from the software Threefish-1024 key schedule for the Skein 1.3 all-zero key/tweak KAT, all-zero plaintext.
  - Required: out_valid rises on edge 101; out_block equals the KAT ciphertext; sk_idx sequence is 0..20.
- Unroll equivalence: same vectors with UNROLL=2 and UNROLL=4 -> identical out_block, at latencies 61 and 41.
- Subkey stall: sk_valid=0 for 5 cycles while sk_idx=3 -> sk_req and sk_idx held at 3, state unchanged during the stall, latency 106, same result.
- Backpressure and busy input:
  - Stimulus: out_ready=0 for 10 cycles in DONE, with in_valid=1 and a new block presented throughout.
  - Required: out_block stable, in_ready=0, second block not accepted. It is accepted one cycle after the out handshake.
- Reset mid-operation: reset=0 at d=37 -> IDLE next edge with all outputs at reset values. A following block completes with correct KAT output. With TF_UBI_FF_EN and all-zero plaintext, out_block equals the raw ciphertext.
